vdecode_issue: RTL and testbench
================================

VDECODE_ISSUE -- requirements
Module: vdecode_issue

Interface
REQ-001 SHALL have parameter NUM_VREGS, default 256, number of vector registers tracked (2**VIDX_W).
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset; synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  instruction word valid.
REQ-005 SHALL have port in_ready  output  1  decoder accepts instruction this cycle.
REQ-006 SHALL have port in_instr  input  32  raw vector instruction word.
REQ-007 SHALL have port out_valid  output  1  decoded instruction held in output register.
REQ-008 SHALL have port out_ready  input  1  downstream (VALU/LSU dispatch) accepts output.
REQ-009 SHALL have port out_ctrl  output  control_t  decoded control bundle.
REQ-010 SHALL have ports out_vs1, out_vs2  output  8 each  source selects; out_imm  output  8; out_rs1  output  8.
REQ-011 SHALL have port wb_valid  input  1  writeback of a vector register completing.
REQ-012 SHALL have port wb_vsel  input  8  register being written back.
REQ-013 SHALL have port illegal  output  1  one-cycle pulse: illegal instruction consumed.

Function
REQ-014 SHALL classify by opcode[6:5] (opcode at in_instr[6:0]): 00 R-type VV, 01 I-type VI, 10 M-type load, 11 M-type store; opcode[4:0] is vop.
REQ-015 SHALL decode: R/I -> valid=2'b01, wen=1, vop=opcode[4:0], valu_src=00 (R) / 10 (I), datatype=00; load -> valid=2'b10, wen=1, memtovreg=1, spread=1, vop=0; store -> valid=2'b10, wen=0, spwrite=1, vop=0.
REQ-016 SHALL set vwsel=vd, vm=mask for all formats; datatype, sp, swizzle from M-type fields for load/store, 0 for R/I.
REQ-017 SHALL treat R/I with vop > 5'h01 (beyond VALU_ADD/VALU_SUB) as illegal.
REQ-018 SHALL keep a NUM_VREGS-bit busy scoreboard; reads: R -> vs1, vs2; I -> vs1; store -> vd; load -> none; dest: vd for R/I/load.
REQ-019 SHALL assert hazard when any read source or the destination (WAW) is busy; illegal instructions never hazard.
REQ-020 SHALL drive in_ready = (!out_valid || out_ready) && !hazard, combinational from current state and in_instr.
REQ-021 SHALL, on accept (in_valid && in_ready) of a legal instruction, load output register and set out_valid next cycle (latency 1); full throughput with out_ready held high and no hazards.
REQ-022 SHALL, on accept of an illegal instruction, not load output register (out_valid falls if previous output was taken), not touch scoreboard, pulse illegal the next cycle.
REQ-023 SHALL set busy[vd] on accept of a legal instruction with wen=1.
REQ-024 SHALL clear busy[wb_vsel] on wb_valid; clear visible to hazard check only from next cycle (no bypass).
REQ-025 SHALL let set win when set and clear target the same register in the same cycle.
REQ-026 SHALL hold out_ctrl and all out_* stable while out_valid && !out_ready.
REQ-027 SHALL ignore in_instr when in_valid=0 (no scoreboard change, no illegal pulse).

Reset
REQ-028 SHALL, while nRST=0 at a rising edge, clear out_valid, illegal, out_ctrl, out_vs1, out_vs2, out_imm, out_rs1 and all scoreboard bits to 0.
REQ-029 SHALL discard an in-flight output and all pending busy bits on reset mid-operation; in_ready is 1 the first cycle after reset.

Structure
REQ-030 SHALL take control_t, rv_rtype_t, rv_itype_t, rv_mtype_t, valu_op_t from vector_pkg; rv_mtype_t SHALL be reordered so opcode occupies bits [6:0], reserve above it.
REQ-031 SHALL add to vector_pkg: format codes (FMT_R/FMT_I/FMT_LD/FMT_ST), FU codes (FU_VALU=2'b01, FU_LSU=2'b10), valu_src codes (SRC_VV=00, SRC_VS=01, SRC_VI=10).
REQ-032 SHALL place the scoreboard in one sub-module vscoreboard (set/clear ports, 3 combinational read checks).

Verification
REQ-033 R-type ADD vd=5, vs1=1, vs2=2, out_ready=1 -> out_valid next cycle, vop=0, valid=01, wen=1, vwsel=5; busy[5]=1.
REQ-034 R-type using vs1=5 while busy[5] -> in_ready=0; wb_valid,wb_vsel=5 at cycle t -> in_ready=1 at t+1, accepted.
REQ-035 Store vd=5 after load vd=5, no writeback -> store stalled (read of busy vd); load decodes memtovreg=1, spread=1, datatype/sp from fields.
REQ-036 R-type vop=5'h03 -> accepted, illegal=1 one cycle, out_valid=0, scoreboard unchanged.
REQ-037 out_ready=0 for 4 cycles with out_valid=1 -> in_ready=0, outputs stable; release -> next instruction accepted same cycle.
REQ-038 Issue vd=7 and wb_vsel=7 same cycle -> busy[7]=1 after; nRST=0 mid-stall -> out_valid=0, all busy clear, in_ready=1.

Source files
------------

// File: rtl/vector_pkg.sv
// Shared vector-unit types: instruction field layouts, decoded control bundle, code points.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vector_pkg;

  localparam int VIDX_W = 8;

  typedef enum logic [4:0] {
    VALU_ADD = 5'h00,
    VALU_SUB = 5'h01
  } valu_op_t;

  // Format is carried in opcode[6:5]
  localparam logic [1:0] FMT_R  = 2'b00;
  localparam logic [1:0] FMT_I  = 2'b01;
  localparam logic [1:0] FMT_LD = 2'b10;
  localparam logic [1:0] FMT_ST = 2'b11;

  // Functional-unit select carried in control_t.valid
  localparam logic [1:0] FU_VALU = 2'b01;
  localparam logic [1:0] FU_LSU  = 2'b10;

  // VALU second-operand source
  localparam logic [1:0] SRC_VV = 2'b00;
  localparam logic [1:0] SRC_VS = 2'b01;
  localparam logic [1:0] SRC_VI = 2'b10;

  typedef struct packed {
    logic              vm;
    logic [VIDX_W-1:0] vs2;
    logic [VIDX_W-1:0] vs1;
    logic [VIDX_W-1:0] vd;
    logic [6:0]        opcode;
  } rv_rtype_t;

  typedef struct packed {
    logic              vm;
    logic [7:0]        imm;
    logic [VIDX_W-1:0] vs1;
    logic [VIDX_W-1:0] vd;
    logic [6:0]        opcode;
  } rv_itype_t;

  // Opcode kept in the low bits like the other formats; spare bit at the top
  typedef struct packed {
    logic              reserve;
    logic              vm;
    logic [2:0]        swizzle;
    logic [1:0]        sp;
    logic [1:0]        datatype;
    logic [7:0]        rs1;
    logic [VIDX_W-1:0] vd;
    logic [6:0]        opcode;
  } rv_mtype_t;

  typedef struct packed {
    logic [1:0]        valid;
    logic              wen;
    logic [4:0]        vop;
    logic [1:0]        valu_src;
    logic [1:0]        datatype;
    logic              memtovreg;
    logic              spread;
    logic              spwrite;
    logic [VIDX_W-1:0] vwsel;
    logic              vm;
    logic [1:0]        sp;
    logic [2:0]        swizzle;
  } control_t;

endpackage

// File: rtl/vscoreboard.sv
// Busy bit per vector register with one set port, one clear port and three lookups.
// Latency: set/clear take effect the cycle after; lookups are combinational on current state.
// Backpressure: none; caller gates set with its own accept.
module vscoreboard
  import vector_pkg::*;
#(
  parameter int NUM_VREGS = 256
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              set_en,
  input  logic [VIDX_W-1:0] set_idx,
  input  logic              clr_en,
  input  logic [VIDX_W-1:0] clr_idx,
  input  logic [VIDX_W-1:0] chk_a_idx,
  input  logic [VIDX_W-1:0] chk_b_idx,
  input  logic [VIDX_W-1:0] chk_c_idx,
  output logic              chk_a_busy,
  output logic              chk_b_busy,
  output logic              chk_c_busy
);

  logic [NUM_VREGS-1:0] busy_q;
  logic [NUM_VREGS-1:0] set_oh;
  logic [NUM_VREGS-1:0] clr_oh;

  assign set_oh = {{(NUM_VREGS-1){1'b0}}, set_en} << set_idx;
  assign clr_oh = {{(NUM_VREGS-1){1'b0}}, clr_en} << clr_idx;

  // Clear first, then set, so an issue to the register being written back stays busy
  always_ff @(posedge CLK) begin
    if (!nRST) busy_q <= '0;
    else       busy_q <= (busy_q & ~clr_oh) | set_oh;
  end

  assign chk_a_busy = busy_q[chk_a_idx];
  assign chk_b_busy = busy_q[chk_b_idx];
  assign chk_c_busy = busy_q[chk_c_idx];

endmodule

// File: rtl/vdecode_issue.sv
// Vector instruction decode + RAW/WAW scoreboard issue stage with a single output register.
// Latency: 1 cycle from accept to out_valid; illegal pulses 1 cycle after accept.
// Backpressure: in_ready drops while output is held (out_ready=0) or on a register hazard.
module vdecode_issue
  import vector_pkg::*;
#(
  parameter int NUM_VREGS = 256
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output control_t    out_ctrl,
  output logic [7:0]  out_vs1,
  output logic [7:0]  out_vs2,
  output logic [7:0]  out_imm,
  output logic [7:0]  out_rs1,
  input  logic        wb_valid,
  input  logic [7:0]  wb_vsel,
  output logic        illegal
);

  rv_rtype_t r_f;
  rv_itype_t i_f;
  rv_mtype_t m_f;
  logic [1:0] fmt;
  logic [4:0] vop;

  control_t   dec_ctrl;
  logic [7:0] dec_vs1, dec_vs2, dec_imm, dec_rs1;
  logic       dec_illegal;
  logic       chk_vs1_en, chk_vs2_en;
  logic       busy_vs1, busy_vs2, busy_vd;
  logic       hazard, accept, load_out;
  logic       unused_bits;

  assign r_f = in_instr;
  assign i_f = in_instr;
  assign m_f = in_instr;
  assign fmt = r_f.opcode[6:5];
  assign vop = r_f.opcode[4:0];
  assign unused_bits = ^{i_f.opcode, m_f.opcode, m_f.reserve};

  // Decode the raw word into the control bundle and operand selects
  always_comb begin
    dec_ctrl    = '0;
    dec_vs1     = '0;
    dec_vs2     = '0;
    dec_imm     = '0;
    dec_rs1     = '0;
    dec_illegal = 1'b0;
    chk_vs1_en  = 1'b0;
    chk_vs2_en  = 1'b0;
    case (fmt)
      FMT_R: begin
        dec_ctrl.valid    = FU_VALU;
        dec_ctrl.wen      = 1'b1;
        dec_ctrl.vop      = vop;
        dec_ctrl.valu_src = SRC_VV;
        dec_ctrl.vwsel    = r_f.vd;
        dec_ctrl.vm       = r_f.vm;
        dec_vs1           = r_f.vs1;
        dec_vs2           = r_f.vs2;
        dec_illegal       = vop > VALU_SUB;
        chk_vs1_en        = 1'b1;
        chk_vs2_en        = 1'b1;
      end
      FMT_I: begin
        dec_ctrl.valid    = FU_VALU;
        dec_ctrl.wen      = 1'b1;
        dec_ctrl.vop      = vop;
        dec_ctrl.valu_src = SRC_VI;
        dec_ctrl.vwsel    = i_f.vd;
        dec_ctrl.vm       = i_f.vm;
        dec_vs1           = i_f.vs1;
        dec_imm           = i_f.imm;
        dec_illegal       = vop > VALU_SUB;
        chk_vs1_en        = 1'b1;
      end
      FMT_LD: begin
        dec_ctrl.valid     = FU_LSU;
        dec_ctrl.wen       = 1'b1;
        dec_ctrl.memtovreg = 1'b1;
        dec_ctrl.spread    = 1'b1;
        dec_ctrl.datatype  = m_f.datatype;
        dec_ctrl.sp        = m_f.sp;
        dec_ctrl.swizzle   = m_f.swizzle;
        dec_ctrl.vwsel     = m_f.vd;
        dec_ctrl.vm        = m_f.vm;
        dec_rs1            = m_f.rs1;
      end
      default: begin
        // store: vd is a read of the data register, not a destination
        dec_ctrl.valid    = FU_LSU;
        dec_ctrl.spwrite  = 1'b1;
        dec_ctrl.datatype = m_f.datatype;
        dec_ctrl.sp       = m_f.sp;
        dec_ctrl.swizzle  = m_f.swizzle;
        dec_ctrl.vwsel    = m_f.vd;
        dec_ctrl.vm       = m_f.vm;
        dec_rs1           = m_f.rs1;
      end
    endcase
  end

  vscoreboard #(.NUM_VREGS(NUM_VREGS)) u_sb (
    .CLK        (CLK),
    .nRST       (nRST),
    .set_en     (load_out && dec_ctrl.wen),
    .set_idx    (r_f.vd),
    .clr_en     (wb_valid),
    .clr_idx    (wb_vsel),
    .chk_a_idx  (r_f.vs1),
    .chk_b_idx  (r_f.vs2),
    .chk_c_idx  (r_f.vd),
    .chk_a_busy (busy_vs1),
    .chk_b_busy (busy_vs2),
    .chk_c_busy (busy_vd)
  );

  // vd is checked for every format: WAW for R/I/load, data read for store
  assign hazard   = !dec_illegal &&
                    ((chk_vs1_en && busy_vs1) || (chk_vs2_en && busy_vs2) || busy_vd);
  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign load_out = accept && !dec_illegal;

  // Output register: load on legal accept, drain when taken, hold otherwise
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
      out_ctrl  <= '0;
      out_vs1   <= '0;
      out_vs2   <= '0;
      out_imm   <= '0;
      out_rs1   <= '0;
    end else begin
      illegal <= accept && dec_illegal;
      if (load_out) begin
        out_valid <= 1'b1;
        out_ctrl  <= dec_ctrl;
        out_vs1   <= dec_vs1;
        out_vs2   <= dec_vs2;
        out_imm   <= dec_imm;
        out_rs1   <= dec_rs1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vdecode_issue.sv
// Directed bench for vdecode_issue with an expected-output queue.
// Latency: checks outputs on the falling edge, one cycle after accept.
// Backpressure: exercises hazard stalls, out_ready holds and mid-stall reset.
module tb_vdecode_issue;
  import vector_pkg::*;

  logic        CLK = 1'b0;
  logic        nRST, in_valid, in_ready, out_valid, out_ready;
  logic        wb_valid, illegal;
  logic [31:0] in_instr;
  logic [7:0]  out_vs1, out_vs2, out_imm, out_rs1, wb_vsel;
  control_t    out_ctrl;

  typedef struct packed {
    control_t   c;
    logic [7:0] vs1;
    logic [7:0] vs2;
    logic [7:0] imm;
    logic [7:0] rs1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_ill = 1'b0;

  always #5 CLK = ~CLK;

  vdecode_issue #(.NUM_VREGS(256)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
    .out_vs1(out_vs1), .out_vs2(out_vs2), .out_imm(out_imm), .out_rs1(out_rs1),
    .wb_valid(wb_valid), .wb_vsel(wb_vsel), .illegal(illegal)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] mk_r(input logic [4:0] vop, input logic [7:0] vd,
                                       input logic [7:0] vs1, input logic [7:0] vs2, input logic vm);
    return {vm, vs2, vs1, vd, 2'b00, vop};
  endfunction

  function automatic logic [31:0] mk_i(input logic [4:0] vop, input logic [7:0] vd,
                                       input logic [7:0] vs1, input logic [7:0] imm, input logic vm);
    return {vm, imm, vs1, vd, 2'b01, vop};
  endfunction

  function automatic logic [31:0] mk_m(input logic st, input logic [4:0] low, input logic [7:0] vd,
                                       input logic [7:0] rs1, input logic [1:0] dt, input logic [1:0] sp,
                                       input logic [2:0] sw, input logic vm);
    return {1'b0, vm, sw, sp, dt, rs1, vd, 1'b1, st, low};
  endfunction

  function automatic logic model_illegal(input logic [31:0] ins);
    return (ins[6] == 1'b0) && (ins[4:0] > 5'h01);
  endfunction

  // Expected decode from the bit positions of each format
  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    e = '0;
    e.c.vwsel = ins[14:7];
    case (ins[6:5])
      2'b00: begin
        e.c.valid = 2'b01; e.c.wen = 1'b1; e.c.vop = ins[4:0]; e.c.valu_src = 2'b00;
        e.c.vm = ins[31]; e.vs1 = ins[22:15]; e.vs2 = ins[30:23];
      end
      2'b01: begin
        e.c.valid = 2'b01; e.c.wen = 1'b1; e.c.vop = ins[4:0]; e.c.valu_src = 2'b10;
        e.c.vm = ins[31]; e.vs1 = ins[22:15]; e.imm = ins[30:23];
      end
      default: begin
        e.c.valid = 2'b10; e.c.datatype = ins[24:23]; e.c.sp = ins[26:25];
        e.c.swizzle = ins[29:27]; e.c.vm = ins[30]; e.rs1 = ins[22:15];
        if (ins[5]) e.c.spwrite = 1'b1;
        else begin e.c.wen = 1'b1; e.c.memtovreg = 1'b1; e.c.spread = 1'b1; end
      end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: compare outputs against the queue head, record this cycle's accept
  task automatic clk_step();
    exp_t e;
    logic ill_n, rst_now;
    @(negedge CLK);
    rst_now = !nRST;
    ill_n   = 1'b0;
    if (!rst_now) begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("illegal", illegal, exp_ill);
      if (out_valid && q.size() != 0) begin
        e = q[0];
        chk("out_ctrl", out_ctrl, e.c);
        chk("out_vs1", out_vs1, e.vs1);
        chk("out_vs2", out_vs2, e.vs2);
        chk("out_imm", out_imm, e.imm);
        chk("out_rs1", out_rs1, e.rs1);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        if (model_illegal(in_instr)) ill_n = 1'b1;
        else q.push_back(model(in_instr));
      end
    end
    @(posedge CLK);
    #1;
    if (rst_now) begin
      q.delete();
      exp_ill = 1'b0;
    end else begin
      exp_ill = ill_n;
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic ordy,
                      input logic wbv, input logic [7:0] wbs, input logic erdy);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    wb_valid  = wbv;
    wb_vsel   = wbs;
    #1;
    chk({tag, ".in_ready"}, in_ready, erdy);
    clk_step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".out_valid"}, out_valid, 1'b0);
    chk({tag, ".illegal"}, illegal, 1'b0);
    chk({tag, ".out_ctrl"}, out_ctrl, 64'h0);
    chk({tag, ".out_vs1"}, out_vs1, 64'h0);
    chk({tag, ".out_vs2"}, out_vs2, 64'h0);
    chk({tag, ".out_imm"}, out_imm, 64'h0);
    chk({tag, ".out_rs1"}, out_rs1, 64'h0);
    in_valid = 1'b0;
    wb_valid = 1'b0;
    in_instr = mk_r(5'h00, 8'd13, 8'd7, 8'd7, 1'b0);
    #1;
    chk({tag, ".in_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_vsel = '0;
    @(posedge CLK); #1;
    clk_step();
    clk_step();
    nRST = 1'b1;
    chk_reset("rst0");

    step("idle",      1'b0, 32'h0,                                 1'b1, 1'b0, 8'd0, 1'b1);
    // RAW on vs1 after ADD to v5; writeback clear visible only a cycle later
    step("add_v5",    1'b1, mk_r(5'h00, 8'd5, 8'd1, 8'd2, 1'b0),   1'b1, 1'b0, 8'd0, 1'b1);
    step("sub_raw0",  1'b1, mk_r(5'h01, 8'd6, 8'd5, 8'd3, 1'b1),   1'b1, 1'b0, 8'd0, 1'b0);
    step("sub_wb",    1'b1, mk_r(5'h01, 8'd6, 8'd5, 8'd3, 1'b1),   1'b1, 1'b1, 8'd5, 1'b0);
    step("sub_go",    1'b1, mk_r(5'h01, 8'd6, 8'd5, 8'd3, 1'b1),   1'b1, 1'b0, 8'd0, 1'b1);
    step("iadd_v8",   1'b1, mk_i(5'h00, 8'd8, 8'd7, 8'hA5, 1'b1),  1'b1, 1'b0, 8'd0, 1'b1);
    // Load with nonzero low opcode bits still decodes vop=0
    step("load_v5",   1'b1, mk_m(1'b0, 5'h1F, 8'd5, 8'h33, 2'd2, 2'd1, 3'd5, 1'b1), 1'b1, 1'b0, 8'd0, 1'b1);
    step("st_stall0", 1'b1, mk_m(1'b1, 5'h00, 8'd5, 8'h44, 2'd1, 2'd3, 3'd2, 1'b0), 1'b1, 1'b0, 8'd0, 1'b0);
    step("st_stall1", 1'b1, mk_m(1'b1, 5'h00, 8'd5, 8'h44, 2'd1, 2'd3, 3'd2, 1'b0), 1'b1, 1'b1, 8'd5, 1'b0);
    step("st_go",     1'b1, mk_m(1'b1, 5'h00, 8'd5, 8'h44, 2'd1, 2'd3, 3'd2, 1'b0), 1'b1, 1'b0, 8'd0, 1'b1);
    // Illegal op whose vs1 is busy: no hazard, no scoreboard effect on v5
    step("ill_vop3",  1'b1, mk_r(5'h03, 8'd5, 8'd6, 8'd6, 1'b0),   1'b1, 1'b0, 8'd0, 1'b1);
    step("st_v5",     1'b1, mk_m(1'b1, 5'h00, 8'd5, 8'h01, 2'd0, 2'd0, 3'd7, 1'b1), 1'b1, 1'b0, 8'd0, 1'b1);
    step("idle2",     1'b0, mk_m(1'b1, 5'h00, 8'd5, 8'h01, 2'd0, 2'd0, 3'd7, 1'b1), 1'b1, 1'b0, 8'd0, 1'b1);
    // Downstream holds for four cycles; output must stay put
    step("add_v10",   1'b1, mk_r(5'h00, 8'd10, 8'd1, 8'd2, 1'b0),  1'b1, 1'b0, 8'd0, 1'b1);
    for (int k = 0; k < 4; k++)
      step("hold",    1'b1, mk_r(5'h01, 8'd11, 8'd1, 8'd2, 1'b0),  1'b0, 1'b0, 8'd0, 1'b0);
    step("release",   1'b1, mk_r(5'h01, 8'd11, 8'd1, 8'd2, 1'b0),  1'b1, 1'b0, 8'd0, 1'b1);
    step("idle3",     1'b0, 32'h0,                                 1'b1, 1'b0, 8'd0, 1'b1);
    // Set and clear of v7 in the same cycle: set wins
    step("add_v7_wb", 1'b1, mk_r(5'h00, 8'd7, 8'd1, 8'd2, 1'b0),   1'b1, 1'b1, 8'd7, 1'b1);
    step("rd7_hold",  1'b1, mk_r(5'h00, 8'd12, 8'd7, 8'd2, 1'b0),  1'b0, 1'b0, 8'd0, 1'b0);
    step("rd7_haz",   1'b1, mk_r(5'h00, 8'd12, 8'd7, 8'd2, 1'b0),  1'b1, 1'b0, 8'd0, 1'b0);
    step("add_v13",   1'b1, mk_r(5'h00, 8'd13, 8'd1, 8'd2, 1'b0),  1'b0, 1'b0, 8'd0, 1'b1);
    step("stall_mid", 1'b1, mk_r(5'h00, 8'd12, 8'd7, 8'd2, 1'b0),  1'b0, 1'b0, 8'd0, 1'b0);
    // Reset in the middle of the stall drops the held output and all busy bits
    nRST = 1'b0;
    clk_step();
    nRST = 1'b1;
    out_ready = 1'b1;
    chk_reset("rst1");

    // Invalid cycles must not pulse illegal nor mark registers busy
    step("nv_ill",    1'b0, mk_r(5'h03, 8'd20, 8'd1, 8'd2, 1'b0),  1'b1, 1'b0, 8'd0, 1'b1);
    step("nv_add20",  1'b0, mk_r(5'h00, 8'd20, 8'd1, 8'd2, 1'b0),  1'b1, 1'b0, 8'd0, 1'b1);
    step("rd20",      1'b1, mk_r(5'h00, 8'd21, 8'd20, 8'd20, 1'b1), 1'b1, 1'b0, 8'd0, 1'b1);
    step("ill_i",     1'b1, mk_i(5'h02, 8'd22, 8'd21, 8'h0F, 1'b0), 1'b1, 1'b0, 8'd0, 1'b1);
    step("idle4",     1'b0, 32'h0,                                 1'b1, 1'b0, 8'd0, 1'b1);
    step("idle5",     1'b0, 32'h0,                                 1'b1, 1'b0, 8'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
